// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: a randomised red phase, a timed green phase and a score store per trial.
// Optional macro FALSE_START_PENALTY_EN: a hit during the red phase records a saturated penalty score.
module reaction_game_ctrl #(
  parameter int SCORE_W   = 13,
  parameter int TRIALS    = 3,
  parameter int ADDR_W    = 3,
  parameter int DELAY_W   = 16,
  parameter int DELAY_MIN = 1000
) (
  input  logic               Clock,
  input  logic               buttonReset,
  input  logic               buttonStart,
  input  logic               buttonHit,
  output logic               ledRed,
  output logic               ledGreen,
  output logic               writeEnable,
  output logic [ADDR_W-1:0]  writeAddress,
  output logic [SCORE_W-1:0] writeData,
  output logic [SCORE_W-1:0] bestScore,
  output logic [ADDR_W:0]    trialCount,
  output logic               done,
  output logic [2:0]         State
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    GO    = 3'd2,
    STORE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [DELAY_W-1:0] DELAY_BASE = DELAY_W'(DELAY_MIN);
  localparam logic [DELAY_W-1:0] DELAY_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]    TRIAL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]    TRIALS_C   = (ADDR_W+1)'(TRIALS);
  localparam logic [15:0]        LFSR_SEED  = 16'hACE1;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [DELAY_W-1:0] delay_q, delay_d, delay_load;
  logic [SCORE_W-1:0] score_q, score_d, best_q, best_d, wdata_q, wdata_d;
  logic [ADDR_W:0]    trial_q, trial_d, trial_inc;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic               red_q, red_d, green_q, green_d, we_q, we_d, done_q, done_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    delay_load = DELAY_BASE + {1'b0, lfsr_q[DELAY_W-2:0]};
    trial_inc  = trial_q + TRIAL_ONE;
    state_d    = state_q;
    delay_d    = delay_q;
    score_d    = score_q;
    best_d     = best_q;
    trial_d    = trial_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE: begin
        if (buttonStart) begin
          state_d = DELAY;
          delay_d = delay_load;
          trial_d = {(ADDR_W+1){1'b0}};
          best_d  = SCORE_MAX;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
`ifdef FALSE_START_PENALTY_EN
        if (buttonHit) begin
          state_d = STORE;
          score_d = SCORE_MAX;
        end else if (delay_q == {DELAY_W{1'b0}}) begin
          state_d = GO;
          score_d = {SCORE_W{1'b0}};
        end else begin
          delay_d = delay_q - DELAY_ONE;
        end
`else
        if (delay_q == {DELAY_W{1'b0}}) begin
          state_d = GO;
          score_d = {SCORE_W{1'b0}};
        end else begin
          delay_d = delay_q - DELAY_ONE;
        end
`endif
      end
      GO: begin
        if (buttonHit) begin
          state_d = STORE;
        end else if (score_q != SCORE_MAX) begin
          score_d = score_q + SCORE_ONE;
        end else begin
          score_d = SCORE_MAX;
        end
      end
      STORE: begin
        state_d = NEXT;
        if (score_q < best_q) begin
          best_d = score_q;
        end else begin
          best_d = best_q;
        end
      end
      NEXT: begin
        trial_d = trial_inc;
        if (trial_inc == TRIALS_C) begin
          state_d = DONE;
        end else begin
          state_d = DELAY;
          delay_d = delay_load;
        end
      end
      DONE: begin
        if (buttonStart) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they line up with State
    red_d   = (state_d == DELAY);
    green_d = (state_d == GO);
    we_d    = (state_d == STORE);
    done_d  = (state_d == DONE);
    if (state_d == STORE) begin
      waddr_d = trial_q[ADDR_W-1:0];
      wdata_d = score_d;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  // State, LFSR and output registers with asynchronous reset
  always_ff @(posedge Clock or posedge buttonReset) begin
    if (buttonReset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      delay_q <= {DELAY_W{1'b0}};
      score_q <= {SCORE_W{1'b0}};
      best_q  <= SCORE_MAX;
      trial_q <= {(ADDR_W+1){1'b0}};
      waddr_q <= {ADDR_W{1'b0}};
      wdata_q <= {SCORE_W{1'b0}};
      red_q   <= 1'b0;
      green_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      delay_q <= delay_d;
      score_q <= score_d;
      best_q  <= best_d;
      trial_q <= trial_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      red_q   <= red_d;
      green_q <= green_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign ledRed       = red_q;
  assign ledGreen     = green_q;
  assign writeEnable  = we_q;
  assign writeAddress = waddr_q;
  assign writeData    = wdata_q;
  assign bestScore    = best_q;
  assign trialCount   = trial_q;
  assign done         = done_q;
  assign State        = state_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Scoreboard bench for reaction_game_ctrl: expected writes are queued by the stimulus and
// popped by a monitor on every writeEnable; red-phase length is checked against a reference LFSR.
module tb_reaction_game_ctrl;

  logic        Clock;
  logic        buttonReset, buttonStart, buttonHit;
  logic        ledRed, ledGreen, writeEnable, done;
  logic [2:0]  writeAddress;
  logic [12:0] writeData, bestScore;
  logic [3:0]  trialCount;
  logic [2:0]  State;

  typedef struct packed {
    logic [2:0]  addr;
    logic [12:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  logic [15:0] lfsr_m, lfsr_prev;
  logic        red_prev = 1'b0;
  int          red_cnt = 0;
  int          red_exp = 0;

  reaction_game_ctrl #(
    .SCORE_W(13), .TRIALS(3), .ADDR_W(3), .DELAY_W(4), .DELAY_MIN(2)
  ) dut (
    .Clock(Clock), .buttonReset(buttonReset), .buttonStart(buttonStart), .buttonHit(buttonHit),
    .ledRed(ledRed), .ledGreen(ledGreen), .writeEnable(writeEnable),
    .writeAddress(writeAddress), .writeData(writeData), .bestScore(bestScore),
    .trialCount(trialCount), .done(done), .State(State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference LFSR: taps 16,14,13,11, shifting left; lfsr_prev is the value the DUT saw at the last edge
  always @(posedge Clock or posedge buttonReset) begin
    if (buttonReset) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge Clock) begin
    if (writeEnable) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(writeAddress), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("write_addr", 32'(writeAddress), 32'(e.addr));
        check("write_data", 32'(writeData), 32'(e.data));
      end
    end
  end

  // Red-phase monitor: counter loads 2+lfsr[2:0] and counts down to 0, so red lasts load+1 cycles
  always @(negedge Clock) begin
    if (buttonReset) begin
      red_prev = 1'b0;
    end else begin
      if (ledRed && !red_prev) begin
        red_cnt = 1;
        red_exp = 2 + int'(lfsr_prev[2:0]) + 1;
      end else if (ledRed) begin
        red_cnt++;
      end else if (red_prev && ledGreen) begin
        check("red_len", 32'(red_cnt), 32'(red_exp));
      end
      red_prev = ledRed;
    end
  end

  task automatic press_start();
    @(negedge Clock) buttonStart = 1'b1;
    @(negedge Clock) buttonStart = 1'b0;
  endtask

  task automatic wait_green();
    int k = 0;
    while (!ledGreen && k < 40) begin
      @(negedge Clock);
      k++;
    end
    check("green_seen", 32'(ledGreen), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge Clock);
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  // Hit so that the green phase sees n non-hit edges: score n, saturating at 8191
  task automatic play_trial(input int n, input int addr);
    wr_t e;
    wait_green();
    e.addr = 3'(addr);
    e.data = (n > 8191) ? 13'h1FFF : 13'(n);
    sb_q.push_back(e);
    repeat (n) @(posedge Clock);
    @(negedge Clock) buttonHit = 1'b1;
    @(negedge Clock) buttonHit = 1'b0;
  endtask

  initial begin
    buttonReset = 1'b1;
    buttonStart = 1'b0;
    buttonHit   = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_state", 32'(State), 32'd0);
    check("rst_leds_we_done", {28'd0, ledRed, ledGreen, writeEnable, done}, 32'd0);
    check("rst_addr_data", {16'd0, writeAddress, writeData}, 32'd0);
    check("rst_trials", 32'(trialCount), 32'd0);
    check("rst_best", 32'(bestScore), 32'd8191);
    buttonReset = 1'b0;
    repeat (2) @(negedge Clock);
    check("idle_after_release", 32'(State), 32'd0);

    // Three identical 5-cycle reactions
    press_start();
    check("start_to_delay", 32'(State), 32'd1);
    play_trial(5, 0);
    play_trial(5, 1);
    play_trial(5, 2);
    wait_done();
    check("g1_trials", 32'(trialCount), 32'd3);
    check("g1_best", 32'(bestScore), 32'd5);
    check("g1_state", 32'(State), 32'd5);

    // DONE -> IDLE -> DELAY, then reactions 9,4,7
    press_start();
    check("done_to_idle", 32'(State), 32'd0);
    check("idle_done_low", 32'(done), 32'd0);
    press_start();
    check("g2_state", 32'(State), 32'd1);
    check("g2_trials_clr", 32'(trialCount), 32'd0);
    check("g2_best_clr", 32'(bestScore), 32'd8191);
    play_trial(9, 0);
    play_trial(4, 1);
    play_trial(7, 2);
    wait_done();
    check("g2_best", 32'(bestScore), 32'd4);

    // Saturation: no hit for 8200 cycles
    press_start();
    press_start();
    play_trial(8200, 0);
    play_trial(2, 1);
    play_trial(6, 2);
    wait_done();
    check("g3_best", 32'(bestScore), 32'd2);

    // Hit during the red phase
    press_start();
    press_start();
    check("g4_in_delay", 32'(ledRed), 32'd1);
`ifdef FALSE_START_PENALTY_EN
    begin
      wr_t e;
      e.addr = 3'd0;
      e.data = 13'h1FFF;
      sb_q.push_back(e);
    end
    buttonHit = 1'b1;
    @(negedge Clock) buttonHit = 1'b0;
    check("penalty_store", 32'(State), 32'd3);
    repeat (2) @(negedge Clock);
    check("penalty_trials", 32'(trialCount), 32'd1);
    check("penalty_redelay", 32'(State), 32'd1);
    play_trial(3, 1);
    play_trial(3, 2);
`else
    buttonHit = 1'b1;
    @(negedge Clock) buttonHit = 1'b0;
    check("early_hit_ignored", 32'(State), 32'd1);
    play_trial(3, 0);
    check("early_hit_trials", 32'(trialCount), 32'd0);
    play_trial(3, 1);
    play_trial(3, 2);
`endif
    wait_done();
    check("g4_trials", 32'(trialCount), 32'd3);
    check("g4_best", 32'(bestScore), 32'd3);

    // Reset pulse during the green phase of trial 2
    press_start();
    press_start();
    play_trial(4, 0);
    wait_green();
    repeat (3) @(negedge Clock);
    buttonReset = 1'b1;
    #1;
    check("abort_state", 32'(State), 32'd0);
    check("abort_trials", 32'(trialCount), 32'd0);
    check("abort_best", 32'(bestScore), 32'd8191);
    check("abort_we", 32'(writeEnable), 32'd0);
    @(negedge Clock) buttonReset = 1'b0;
    repeat (20) @(negedge Clock);
    check("abort_idle", 32'(State), 32'd0);
    press_start();
    play_trial(6, 0);
    play_trial(6, 1);
    play_trial(6, 2);
    wait_done();
    check("g5_trials", 32'(trialCount), 32'd3);
    check("g5_best", 32'(bestScore), 32'd6);

    repeat (5) @(negedge Clock);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
